// File: rtl/boa_pkg.sv
// Shared types and constants for the boa_pmp_guard memory-access guard.
package boa_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1,
        FETCH = 2'd2
    } boa_guard_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } boa_guard_state_t;

    localparam logic [3:0] RV_EXC_INSTR_MISALIGNED    = 4'd0;
    localparam logic [3:0] RV_EXC_INSTR_ACCESS_FAULT  = 4'd1;
    localparam logic [3:0] RV_EXC_LOAD_MISALIGNED     = 4'd4;
    localparam logic [3:0] RV_EXC_LOAD_ACCESS_FAULT   = 4'd5;
    localparam logic [3:0] RV_EXC_STORE_MISALIGNED    = 4'd6;
    localparam logic [3:0] RV_EXC_STORE_ACCESS_FAULT  = 4'd7;

    // The reserved request kind encoding behaves exactly like a load.
    function automatic boa_guard_kind_t decode_kind(input logic [1:0] raw);
        case (raw)
            2'd1:    return STORE;
            2'd2:    return FETCH;
            default: return LOAD;
        endcase
    endfunction

endpackage

// File: rtl/boa_pmp_guard_perm.sv
// Combinational permission/alignment decoder for boa_pmp_guard.
// Optional alignment check enabled by defining BOA_PMP_GUARD_MISALIGN_EN;
// a misaligned access wins over an access fault.
module boa_pmp_guard_perm
    import boa_pkg::*;
(
    input  boa_guard_kind_t kind,
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic            r,
    input  logic            w,
    input  logic            x,
    output logic            fault,
    output logic [3:0]      cause
);

    logic granted;
    logic misaligned;

`ifdef BOA_PMP_GUARD_MISALIGN_EN
    // Alignment to the access size; size 3 is never a legal access here.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr_lo[0];
            2'd2:    misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase
    end
`else
    logic unused_align;
    assign unused_align = ^{size, addr_lo};
    assign misaligned   = 1'b0;
`endif

    // Pick the permission bit the access kind needs and derive the fault cause.
    always_comb begin
        granted = 1'b0;
        fault   = 1'b0;
        cause   = 4'd0;
        case (kind)
            STORE:   granted = w;
            FETCH:   granted = x;
            default: granted = r;
        endcase
        if (misaligned) begin
            fault = 1'b1;
            case (kind)
                STORE:   cause = RV_EXC_STORE_MISALIGNED;
                FETCH:   cause = RV_EXC_INSTR_MISALIGNED;
                default: cause = RV_EXC_LOAD_MISALIGNED;
            endcase
        end else if (!granted) begin
            fault = 1'b1;
            case (kind)
                STORE:   cause = RV_EXC_STORE_ACCESS_FAULT;
                FETCH:   cause = RV_EXC_INSTR_ACCESS_FAULT;
                default: cause = RV_EXC_LOAD_ACCESS_FAULT;
            endcase
        end
    end

endmodule

// File: rtl/boa_pmp_guard.sv
// Memory-access guard in front of boa_pmp: checks one request against the
// PMP checker, then either forwards it to the bus or returns an access fault.
// Optional alignment check enabled by defining BOA_PMP_GUARD_MISALIGN_EN.
module boa_pmp_guard
    import boa_pkg::*;
#(
    parameter int FAULT_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic [1:0]             req_kind,
    input  logic [1:0]             req_size,
    input  logic                   req_m_mode,
    input  logic [31:0]            req_wdata,
    output logic [29:0]            pmp_addr,
    output logic                   pmp_m_mode,
    input  logic                   pmp_r,
    input  logic                   pmp_w,
    input  logic                   pmp_x,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [31:0]            bus_addr,
    output logic                   bus_we,
    output logic [31:0]            bus_wdata,
    input  logic [31:0]            bus_rdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_fault,
    output logic [3:0]             rsp_cause,
    output logic [31:0]            rsp_tval,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    boa_guard_state_t state;
    boa_guard_state_t state_next;

    logic [31:0]     addr_q;
    boa_guard_kind_t kind_q;
    logic [1:0]      size_q;
    logic            m_mode_q;
    logic [31:0]     wdata_q;
    logic            fault_q;
    logic [3:0]      cause_q;
    logic [31:0]     rdata_q;
    logic            perm_fault;
    logic [3:0]      perm_cause;

    boa_pmp_guard_perm u_perm (
        .kind    (kind_q),
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .r       (pmp_r),
        .w       (pmp_w),
        .x       (pmp_x),
        .fault   (perm_fault),
        .cause   (perm_cause)
    );

    assign pmp_addr   = addr_q[31:2];
    assign pmp_m_mode = m_mode_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;

    // State register; reset drops back to IDLE at once, abandoning any bus transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/response outputs; response fields read zero outside RESP.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_we     = 1'b0;
        rsp_valid  = 1'b0;
        rsp_fault  = 1'b0;
        rsp_cause  = 4'd0;
        rsp_tval   = 32'd0;
        rsp_rdata  = 32'd0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = perm_fault ? RESP : BUS;
            end
            BUS: begin
                bus_valid = 1'b1;
                bus_we    = (kind_q == STORE);
                if (bus_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_fault  = fault_q;
                rsp_cause  = fault_q ? cause_q : 4'd0;
                rsp_tval   = fault_q ? addr_q : 32'd0;
                rsp_rdata  = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the request on accept, the check result in CHECK and read data on bus completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'd0;
            kind_q   <= LOAD;
            size_q   <= 2'd0;
            m_mode_q <= 1'b0;
            wdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= 4'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                kind_q   <= decode_kind(req_kind);
                size_q   <= req_size;
                m_mode_q <= req_m_mode;
                wdata_q  <= req_wdata;
            end
            if (state == CHECK) begin
                fault_q <= perm_fault;
                cause_q <= perm_cause;
                rdata_q <= 32'd0;
            end
            if (state == BUS && bus_ready) begin
                rdata_q <= (kind_q == STORE) ? 32'd0 : bus_rdata;
            end
        end
    end

    // Saturating count of fault responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if (state == RESP && fault_q && fault_cnt != '1) begin
            fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
        end
    end

endmodule

// File: doc/boa_pmp_guard.md
# boa_pmp_guard

Memory-access guard stage that sits directly upstream of `boa_pmp`. It accepts one load/store/fetch request at a time from the core, presents the word address to one PMP checker port and evaluates the returned permissions. It then either forwards the access to the memory bus or returns a RISC-V access-fault response with cause code and `mtval`, without issuing any bus traffic.

## Interface
Parameters:
- `FAULT_CNT_W`, default 16: width of the saturating fault counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_addr` in 32: byte address.
- `req_kind` in 2: 0 = load, 1 = store, 2 = fetch; 3 is reserved and treated as load.
- `req_size` in 2: log2 of the access size in bytes (0..2).
- `req_m_mode` in 1: access is made in M-mode.
- `req_wdata` in 32: store data.
- `pmp_addr` out 30: word address to the PMP checker.
- `pmp_m_mode` out 1: privilege sent to the PMP checker.
- `pmp_r`, `pmp_w`, `pmp_x` in 1 each: permissions returned by the checker (combinational).
- `bus_valid` out 1: bus request strobe.
- `bus_ready` in 1: bus handshake.
- `bus_addr` out 32, `bus_we` out 1, `bus_wdata` out 32: bus request fields.
- `bus_rdata` in 32: read data, valid on the `bus_ready` cycle.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: response read data.
- `rsp_fault` out 1: the response is a fault.
- `rsp_cause` out 4: mcause exception code.
- `rsp_tval` out 32: faulting address.
- `fault_cnt` out `FAULT_CNT_W`: saturating count of faults.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On a handshake, capture addr/kind/size/m_mode/wdata and go to CHECK.
  - CHECK: `pmp_addr`=captured addr[31:2] and `pmp_m_mode`=captured m_mode. Sample `pmp_r/w/x`. Required permission: load needs r, store needs w, fetch needs x.
    - If the permission is granted, go to BUS.
    - Otherwise, go to RESP with a fault.
  - BUS: `bus_valid`=1 with the captured fields; `bus_we` = (kind==store). Hold all fields stable until `bus_ready`. On `bus_ready`, capture `bus_rdata` and go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- Fault causes: fetch 1, load 5, store 7. `rsp_tval` = captured addr. `rsp_rdata` = 0 on a fault.
- Non-fault response: `rsp_fault`=0, `rsp_cause`=0, `rsp_tval`=0. Stores return `rsp_rdata`=0.
- `pmp_addr` and `pmp_m_mode` are driven from the capture registers in every state, and are 0 after reset.
- `fault_cnt` increments on each RESP cycle with `rsp_fault`=1 and saturates at all-ones.
- There is no response backpressure. The core must sink `rsp_valid`.
- Reset-value outputs:
  - Control: `req_ready`=0 while `rst` is high, 1 in IDLE after release. `bus_valid`=0, `bus_we`=0.
  - Response: `rsp_valid`=0, `rsp_fault`=0, `rsp_cause`=0.
  - Data: `bus_addr`=0, `bus_wdata`=0, `rsp_rdata`=0, `rsp_tval`=0.
  - Counter and PMP port: `fault_cnt`=0, `pmp_addr`=0, `pmp_m_mode`=0.
- Reset asserted mid-operation, including in BUS: all state clears immediately. `bus_valid` drops asynchronously and any in-flight bus transfer is abandoned.

## Timing
- Accept at cycle 0, CHECK at cycle 1.
- A fault gives `rsp_valid` at cycle 2.
- A granted access gives `bus_valid` from cycle 2. If `bus_ready` arrives at cycle N, `rsp_valid` is at N+1. Best-case load latency is 3 cycles.
- Throughput is one request per 3 cycles minimum. `req_ready` is low from the accept cycle+1 until the RESP cycle inclusive, and high again the cycle after RESP.
- `bus_ready` outside BUS is ignored.
- Permissions sampled outside CHECK are ignored.

## Configuration
- `BOA_PMP_GUARD_MISALIGN_EN`, when defined, adds an alignment check in CHECK before the permission check:
  - An address not aligned to `1<<req_size` faults with cause fetch 0, load 4, store 6, and `rsp_tval`=addr.
  - A misaligned access takes precedence over an access fault.
  - A `req_size` of 3 is treated as misaligned.
- When undefined, no alignment check is made. `bus_addr` carries the unmodified byte address, and the permission check uses addr[31:2] only.

## Structure
- Shared package `boa_pkg` holds:
  - `boa_guard_kind_t` (LOAD/STORE/FETCH)
  - `boa_guard_state_t` (IDLE/CHECK/BUS/RESP)
  - cause-code constants `RV_EXC_*_ACCESS_FAULT` and `RV_EXC_*_MISALIGNED`
- One natural sub-module, `boa_pmp_guard_perm`: a combinational decoder mapping kind, size, addr[1:0] and r/w/x to (fault, cause).

## Test plan
- Load 0x0000_0010, PMP stub r=1, `bus_ready` the first BUS cycle, `bus_rdata`=0xDEADBEEF -> `pmp_addr`=0x4 at cycle 1; `rsp_valid` at cycle 3 with `rsp_rdata`=0xDEADBEEF and `rsp_fault`=0.
- Store 0x0000_0020, w=0 -> no `bus_valid`; `rsp_valid` at cycle 2 with cause 7, `rsp_tval`=0x20, `fault_cnt`=1.
- Fetch 0x0000_0008, x=1, `bus_ready` delayed 4 cycles -> `bus_addr`/`bus_we` stable for 5 cycles, `bus_we`=0; single `rsp_valid` pulse.
- Assert `rst` while in BUS -> `bus_valid`=0 in the same cycle; after release, state is IDLE and `req_ready`=1.
- With `FAULT_CNT_W`=2, issue 5 faulting loads -> `fault_cnt` reads 1, 2, 3, 3, 3.
- With `BOA_PMP_GUARD_MISALIGN_EN` defined, load size 2 at 0x0000_0006 with r=0 -> cause 4, `rsp_tval`=0x6.
